// File: rtl/spi_pkg.sv
// Shared definitions for the SPI word-level datapath.
package spi_pkg;

  localparam int unsigned SPI_DW         = 32;
  localparam int unsigned SPI_FIFO_DEPTH = 16;

  typedef logic [SPI_DW-1:0] spi_word_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with registered head (no fall-through), separate level counter and flush.
module spi_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  output logic [DW-1:0]          head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q;
  logic          do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  // Masked so the head reads zero whenever nothing valid is stored.
  assign head    = empty ? '0 : mem[rptr_q];

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= push_data;
  end

endmodule

// File: rtl/spi_word_buffer.sv
// TX/RX word buffering in front of the SPI master, with RX credit reservation before each launch.
module spi_word_buffer
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH = SPI_FIFO_DEPTH,
  parameter int unsigned DW    = SPI_DW
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   clear,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [DW-1:0]          wr_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [DW-1:0]          rd_data,
  output logic                   m_tx_valid,
  input  logic                   m_tx_ready,
  output logic [DW-1:0]          m_tx_data,
  input  logic [DW-1:0]          m_rx_data,
  input  logic                   m_rx_valid,
  output logic [$clog2(DEPTH):0] tx_level,
  output logic [$clog2(DEPTH):0] rx_level,
  output logic                   busy,
  output logic                   rx_overflow
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam logic [LW:0] CREDIT_MAX = (LW + 1)'(DEPTH);

  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_hs, rx_counted, rx_dec, rx_push;
  logic [LW:0]   credit_sum;
  logic [LW-1:0] drop_total;

  logic [LW-1:0] outstanding_q, outstanding_d;
  logic [LW-1:0] drop_cnt_q, drop_cnt_d;
  logic          overflow_q, overflow_d;

  assign credit_sum = {1'b0, rx_level} + {1'b0, outstanding_q};
  assign m_tx_valid = !tx_empty && (credit_sum < CREDIT_MAX) && !clear;
  assign tx_hs      = m_tx_valid && m_tx_ready;

  // Words returning while drop_cnt is nonzero belong to a flushed transfer.
  assign rx_counted = m_rx_valid && (drop_cnt_q == '0);
  assign rx_push    = rx_counted;
  assign rx_dec     = rx_counted && ((outstanding_q != '0) || tx_hs);
  assign drop_total = drop_cnt_q + outstanding_q;

  assign wr_ready    = !tx_full;
  assign rd_valid    = !rx_empty;
  assign busy        = !tx_empty || (outstanding_q != '0);
  assign rx_overflow = overflow_q;

  spi_sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_tx_fifo (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .flush     (clear),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (tx_hs),
    .head      (m_tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level)
  );

  spi_sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_rx_fifo (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .flush     (clear),
    .push      (rx_push),
    .push_data (m_rx_data),
    .pop       (rd_ready),
    .head      (rd_data),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level)
  );

  always_comb begin
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    overflow_d    = overflow_q;
    if (clear) begin
      // Everything still in flight is discarded on return; a same-cycle return consumes one.
      outstanding_d = '0;
      overflow_d    = 1'b0;
      drop_cnt_d    = drop_total;
      if (m_rx_valid && (drop_total != '0)) drop_cnt_d = drop_total - LW'(1);
    end else begin
      if (m_rx_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - LW'(1);
      unique case ({tx_hs, rx_dec})
        2'b10:   outstanding_d = outstanding_q + LW'(1);
        2'b01:   outstanding_d = outstanding_q - LW'(1);
        default: outstanding_d = outstanding_q;
      endcase
      if (rx_counted && rx_full) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      overflow_q    <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      overflow_q    <= overflow_d;
    end
  end

endmodule
